// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared constants for the 4-bit async FIFO and its read-side packer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int NIB_W_DEF  = 4;
  localparam int DATA_WIDTH = NIB_W_DEF;
  localparam int ADDR_WIDTH = 4;

  // Accumulator occupancy, derived purely from the nibble count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  function automatic int nib_cnt_w(input int nibs);
    return $clog2(nibs + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_nibble_packer_nibble_acc.sv
// ============================================================================
// Module : nibble_acc
// Brief  : Nibble accumulator: captures nibbles LSB-first, clears on word load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_acc
  import fifo_pkg::*;
#(
  parameter  int NIB_W = NIB_W_DEF,
  parameter  int NIBS  = 2,
  localparam int OUT_W = NIB_W * NIBS,
  localparam int CW    = nib_cnt_w(NIBS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cap,
  input  logic             i_clr,
  input  logic [NIB_W-1:0] i_data,
  output logic [OUT_W-1:0] o_acc,
  output logic [CW-1:0]    o_cnt,
  output logic [1:0]       o_state
);

  logic [CW-1:0]    r_cnt;
  logic [OUT_W-1:0] r_acc;

  // Clear and capture never coincide: a load needs a full acc or no read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_cap) begin
      r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < NIBS; i++) begin
        if (r_cnt == CW'(i)) begin
          r_acc[i*NIB_W +: NIB_W] <= i_data;
        end
      end
    end
  end

  always_comb begin
    o_state = ST_FILL;
    if (r_cnt == '0) begin
      o_state = ST_EMPTY;
    end else if (r_cnt == CW'(NIBS)) begin
      o_state = ST_FULL;
    end
  end

  assign o_acc = r_acc;
  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/fifo_nibble_packer.sv
// ============================================================================
// Module : fifo_nibble_packer
// Brief  : Pops nibbles from the async FIFO read side and packs them into
//          words on a valid/ready master port, with flush and idle timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter  int NIB_W   = NIB_W_DEF,
  parameter  int NIBS    = 2,
  parameter  int TIMEOUT = 15,
  localparam int OUT_W   = NIB_W * NIBS,
  localparam int CW      = nib_cnt_w(NIBS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [NIB_W-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [CW-1:0]    m_cnt,
  output logic [7:0]       word_cnt
);

  localparam logic [CW:0] C_NIBS = (CW+1)'(NIBS);

  logic             r_rd_pend;
  logic             r_flush_pend;
  logic             r_m_valid;
  logic [OUT_W-1:0] r_m_data;
  logic [CW-1:0]    r_m_cnt;
  logic [7:0]       r_word_cnt;

  logic [OUT_W-1:0] w_acc;
  logic [CW-1:0]    w_acc_cnt;
  logic [1:0]       w_state;
  logic             w_rd_en;
  logic             w_timeout;
  logic             w_partial;
  logic             w_load;
  logic             w_load_fire;
  logic             w_nothing;

  nibble_acc #(
    .NIB_W (NIB_W),
    .NIBS  (NIBS)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_cap   (r_rd_pend),
    .i_clr   (w_load_fire),
    .i_data  (fifo_rd_data),
    .o_acc   (w_acc),
    .o_cnt   (w_acc_cnt),
    .o_state (w_state)
  );

  // Never request more nibbles than the accumulator can still take; held low in reset.
  assign w_rd_en = rst_n && !fifo_empty && !r_flush_pend &&
                   (({1'b0, w_acc_cnt} + {{CW{1'b0}}, r_rd_pend}) < C_NIBS);

  assign w_nothing   = (w_state == ST_EMPTY) && !r_rd_pend;
  assign w_partial   = r_flush_pend || w_timeout;
  assign w_load      = (w_state == ST_FULL) ||
                       (w_partial && (w_state == ST_FILL) && !r_rd_pend);
  assign w_load_fire = w_load && (!r_m_valid || m_ready);

  generate
    if (TIMEOUT != 0) begin : g_tmo
      localparam int            IW    = $clog2(TIMEOUT + 1);
      localparam logic [IW-1:0] C_TMO = IW'(TIMEOUT);
      logic [IW-1:0] r_idle;
      logic          w_idle;

      assign w_idle = (w_state == ST_FILL) && !r_rd_pend && fifo_empty;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_idle <= '0;
        end else if (!w_idle) begin
          r_idle <= '0;
        end else if (r_idle != C_TMO) begin
          r_idle <= r_idle + 1'b1;
        end
      end

      assign w_timeout = (r_idle == C_TMO);
    end else begin : g_no_tmo
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_cnt      <= '0;
      r_word_cnt   <= '0;
    end else begin
      r_rd_pend <= w_rd_en;

      // A flush with nothing held or in flight has nothing to emit and is dropped.
      if (w_load_fire || w_nothing) begin
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end

      if (w_load_fire) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_acc;
        r_m_cnt   <= w_acc_cnt;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end

      if (r_m_valid && m_ready) begin
        r_word_cnt <= r_word_cnt + 8'd1;
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_cnt      = r_m_cnt;
  assign word_cnt   = r_word_cnt;

endmodule

`default_nettype wire
